timer: RTL and testbench

//  - Retriggerable on-delay (qualification) timer: hit_target asserts once input `in`
//    has been continuously high for `target` clock edges.
//  - Deasserts immediately when `in` drops.
//  - Used in the RPSC card logic for power-supply settle delays (e.g. G1 2 s, anode 4 s)
//    and shortened for simulation.
//  - One instance per delay; target supplied as a port so one build serves run-time or

---
 rtl/timer.sv | 38 +++
 tb/tb_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// Retriggerable on-delay timer: hit_target goes high once `in` has been
// continuously high for `target` rising clock edges. It drops in the same
// cycle that `in` falls, and the next rise of `in` starts the full delay again.
module timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
  output logic             hit_target
);

  logic [WIDTH-1:0] count;
  logic             reached;

  // Magnitude compare against the live target. A target lowered to or below
  // the current count is honoured at once.
  assign reached = (count >= target);

  // Qualification counter. Low `in` clears it, so time spent high is never
  // carried across a gap. While `in` is high the counter climbs to the target
  // and then holds, which means it cannot wrap even at target = all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!in) begin
      count <= '0;
    end else if (!reached) begin
      count <= count + WIDTH'(1);
    end
  end

  // The output is gated by the live input, so a falling `in` drops it
  // without waiting for the counter to clear on the next edge.
  assign hit_target = in & reached;

endmodule

// File: tb/tb_timer.sv
// Directed testbench for timer (WIDTH=4). Expected values are hand-derived
// from the edge counts given for each scenario.
module tb_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] target;
  logic             in;
  logic             hit_target;

  int total;
  int bad;

  timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .target     (target),
    .in         (in),
    .hit_target (hit_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    in     = 1'b0;
    target = 4'd8;

    // Reset state
    #2;
    chk("reset_hit", 32'(hit_target), 0);
    chk("reset_count", 32'(dut.count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic delay: target=8
    in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("basic_hit_low", 32'(hit_target), 0);
      chk("basic_count", 32'(dut.count), 32'(i));
    end
    step();
    chk("basic_hit_edge8", 32'(hit_target), 1);
    chk("basic_count8", 32'(dut.count), 8);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("basic_sat_hit", 32'(hit_target), 1);
      chk("basic_sat_count", 32'(dut.count), 8);
    end

    // Asynchronous reset in the middle of a count
    in = 1'b0;
    step();
    chk("clear_count", 32'(dut.count), 0);
    in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_count", 32'(dut.count), 5);
    #2 reset = 1'b1;
    #1;
    chk("midreset_count", 32'(dut.count), 0);
    chk("midreset_hit", 32'(hit_target), 0);
    #1 reset = 1'b0;
    in = 1'b0;
    step();

    // Drop and retrigger: 5 edges high, 1 edge low, then high again
    in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("retrig_pre_count", 32'(dut.count), 5);
    in = 1'b0;
    step();
    chk("glitch_count", 32'(dut.count), 0);
    in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("retrig_hit_low", 32'(hit_target), 0);
    end
    step();
    chk("retrig_hit_edge8", 32'(hit_target), 1);
    in = 1'b0;
    #1;
    chk("drop_same_cycle", 32'(hit_target), 0);
    chk("drop_count_held", 32'(dut.count), 8);
    step();
    chk("drop_count_cleared", 32'(dut.count), 0);

    // Maximum target: saturate at all-ones
    target = 4'd15;
    in = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("max_hit_low", 32'(hit_target), 0);
    end
    step();
    chk("max_hit_edge15", 32'(hit_target), 1);
    chk("max_count15", 32'(dut.count), 15);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("max_nowrap_count", 32'(dut.count), 15);
      chk("max_nowrap_hit", 32'(hit_target), 1);
    end
    in = 1'b0;
    step();

    // Target zero: output follows the input
    target = 4'd0;
    for (int i = 0; i < 8; i++) begin
      in = ((i % 3) != 0);
      #1;
      chk("t0_follow_comb", 32'(hit_target), 32'(in));
      step();
      chk("t0_follow_edge", 32'(hit_target), 32'(in));
      chk("t0_count", 32'(dut.count), 0);
    end

    // Live target change
    target = 4'd8;
    in = 1'b0;
    step();
    in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("live_count6", 32'(dut.count), 6);
    chk("live_hit_before", 32'(hit_target), 0);
    target = 4'd4;
    #1;
    chk("live_lower_hit", 32'(hit_target), 1);
    step();
    chk("live_lower_hold", 32'(dut.count), 6);
    target = 4'd12;
    #1;
    chk("live_raise_hit_low", 32'(hit_target), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("live_raise_wait", 32'(hit_target), 0);
      chk("live_raise_count", 32'(dut.count), 32'(6 + i));
    end
    step();
    chk("live_raise_hit", 32'(hit_target), 1);
    chk("live_raise_count12", 32'(dut.count), 12);

    // Idle: input low for 50 edges
    target = 4'd8;
    in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_hit", 32'(hit_target), 0);
      chk("idle_count", 32'(dut.count), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
